fp_fetch_unpack: RTL and testbench

FP_FETCH_UNPACK -- requirements
Module: fp_fetch_unpack

---
 rtl/fp_fetch_unpack.sv | 111 +++++++++++
 tb/tb_fp_fetch_unpack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_fetch_unpack.sv
// fp_fetch_unpack: classifies and unpacks an IEEE-style operand pair into a 2-entry skid-buffered output stage
module fp_fetch_unpack #(
  parameter int EXP_W = 8,
  parameter int MANT_W = 23,
  parameter int TAG_W = 4,
  localparam int FP_W = 1 + EXP_W + MANT_W,
  localparam int SIG_W = MANT_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [FP_W-1:0]   a_i,
  input  logic [FP_W-1:0]   b_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              a_sign_o,
  output logic              b_sign_o,
  output logic [EXP_W-1:0]  a_exp_o,
  output logic [EXP_W-1:0]  b_exp_o,
  output logic [SIG_W-1:0]  a_sig_o,
  output logic [SIG_W-1:0]  b_sig_o,
  output logic [4:0]        a_cls_o,
  output logic [4:0]        b_cls_o,
  output logic [1:0]        status_o,
  output logic [TAG_W-1:0]  tag_o
);
  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] m;
    logic [4:0]       c;
  } op_t;
  typedef struct packed {
    op_t              a;
    op_t              b;
    logic [1:0]       st;
    logic [TAG_W-1:0] tag;
  } ent_t;
  function automatic op_t unpack(input logic [FP_W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MANT_W-1:0] f;
    logic e1, e0, fz;
    op_t o;
    e = x[FP_W-2:MANT_W];
    f = x[MANT_W-1:0];
    e1 = &e;
    e0 = ~|e;
    fz = ~|f;
    o.s = x[FP_W-1];
    o.c = {e1 & ~fz, e1 & fz, ~e1 & ~e0, e0 & ~fz, e0 & fz};
    o.e = (e0 & ~fz) ? EXP_W'(1) : e;
    o.m = {~e1 & ~e0, f};
    return o;
  endfunction
  ent_t w_new, w_rst, r_out, r_skid;
  logic r_out_v, r_skid_e, w_in_xfer, w_out_xfer;
  always_comb begin
    w_new.a = unpack(a_i);
    w_new.b = unpack(b_i);
    w_new.tag = tag_i;
    w_new.st = (w_new.a.c[0] & w_new.b.c[0]) ? 2'b01 :
               (|{w_new.a.c[4:3], w_new.b.c[4:3]}) ? 2'b10 : 2'b00;
    w_rst = '0;
    w_rst.a.c = 5'b00001;
    w_rst.b.c = 5'b00001;
  end
  assign w_in_xfer = in_valid_i & r_skid_e;
  assign w_out_xfer = r_out_v & out_ready_i;
  // in_ready comes straight from the skid-empty flop, so out_ready never reaches it combinationally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out <= w_rst;
      r_skid <= w_rst;
      r_out_v <= 1'b0;
      r_skid_e <= 1'b1;
    end else if (flush_i) begin
      r_out_v <= 1'b0;
      r_skid_e <= 1'b1;
    end else if (!r_skid_e) begin
      if (w_out_xfer) begin
        r_out <= r_skid;
        r_skid_e <= 1'b1;
      end
    end else if (w_in_xfer) begin
      if (!r_out_v || w_out_xfer) begin
        r_out <= w_new;
        r_out_v <= 1'b1;
      end else begin
        r_skid <= w_new;
        r_skid_e <= 1'b0;
      end
    end else if (w_out_xfer) begin
      r_out_v <= 1'b0;
    end
  end
  assign in_ready_o = r_skid_e;
  assign out_valid_o = r_out_v;
  assign a_sign_o = r_out.a.s;
  assign b_sign_o = r_out.b.s;
  assign a_exp_o = r_out.a.e;
  assign b_exp_o = r_out.b.e;
  assign a_sig_o = r_out.a.m;
  assign b_sig_o = r_out.b.m;
  assign a_cls_o = r_out.a.c;
  assign b_cls_o = r_out.b.c;
  assign status_o = r_out.st;
  assign tag_o = r_out.tag;
endmodule

// File: tb/tb_fp_fetch_unpack.sv
// tb_fp_fetch_unpack: directed and randomized scoreboard bench for the unpack stage
module tb_fp_fetch_unpack;
  logic clk, rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] a_i, b_i;
  logic [3:0] tag_i, tag_o;
  logic a_sign_o, b_sign_o;
  logic [7:0] a_exp_o, b_exp_o;
  logic [23:0] a_sig_o, b_sig_o;
  logic [4:0] a_cls_o, b_cls_o;
  logic [1:0] status_o;
  int checks = 0, failures = 0, npop = 0;
  logic [81:0] sb[$];
  logic [31:0] vals[8] = '{32'h0, 32'h80000000, 32'h1, 32'h7F800000,
                           32'hFF800001, 32'h7FC00000, 32'h3F800000, 32'h00400000};

  fp_fetch_unpack dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .a_sign_o(a_sign_o), .b_sign_o(b_sign_o), .a_exp_o(a_exp_o), .b_exp_o(b_exp_o),
    .a_sig_o(a_sig_o), .b_sig_o(b_sig_o), .a_cls_o(a_cls_o), .b_cls_o(b_cls_o),
    .status_o(status_o), .tag_o(tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] model_op(logic [31:0] x);
    logic [7:0] e;
    logic [22:0] f;
    logic [4:0] c;
    e = x[30:23];
    f = x[22:0];
    if (e == 8'hFF) c = (f != 0) ? 5'b10000 : 5'b01000;
    else if (e == 8'h00) c = (f == 0) ? 5'b00001 : 5'b00010;
    else c = 5'b00100;
    return {x[31], (c == 5'b00010) ? 8'd1 : e, c == 5'b00100, f, c};
  endfunction

  function automatic logic [81:0] model(logic [31:0] a, logic [31:0] b, logic [3:0] t);
    logic [37:0] ma, mb;
    logic [1:0] st;
    ma = model_op(a);
    mb = model_op(b);
    if (ma[0] && mb[0]) st = 2'b01;
    else if (ma[4] || ma[3] || mb[4] || mb[3]) st = 2'b10;
    else st = 2'b00;
    return {ma, mb, st, t};
  endfunction

  function automatic logic [81:0] obs();
    return {a_sign_o, a_exp_o, a_sig_o, a_cls_o, b_sign_o, b_exp_o, b_sig_o, b_cls_o, status_o, tag_o};
  endfunction

  task automatic chk(string tag, logic [127:0] o, logic [127:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic tick();
    logic [81:0] e;
    @(negedge clk);
    if (rst_i || flush_i) sb.delete();
    else begin
      if (out_valid_o && out_ready_i) begin
        chk("sb_nonempty_on_out", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_pair", obs(), e);
          npop++;
        end
      end
      if (in_valid_i && in_ready_o) sb.push_back(model(a_i, b_i, tag_i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] a, logic [31:0] b, logic [3:0] t);
    a_i = a;
    b_i = b;
    tag_i = t;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    in_valid_i = 1'b0;
    for (int i = 0; i < 10 && (sb.size() != 0 || out_valid_o); i++) tick();
    chk("drain_empty", sb.size(), 0);
    chk("drain_out_valid", out_valid_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; tag_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_data", obs(), {1'b0, 8'd0, 24'd0, 5'b00001, 1'b0, 8'd0, 24'd0, 5'b00001, 2'b00, 4'd0});
    // single-cycle latency and the reference unpack values
    send(32'h3F800000, 32'h40000000, 4'd3);
    chk("lat_valid", out_valid_o, 1);
    chk("one_exp", {a_exp_o, b_exp_o}, {8'd127, 8'd128});
    chk("one_sig", {a_sig_o, b_sig_o}, {24'h800000, 24'h800000});
    chk("one_cls", {a_cls_o, b_cls_o, status_o, tag_o}, {5'b00100, 5'b00100, 2'b00, 4'd3});
    send(32'h00000000, 32'h80000000, 4'd4);
    chk("zero_status", status_o, 2'b01);
    chk("zero_cls", {a_cls_o, b_cls_o, b_sign_o}, {5'b00001, 5'b00001, 1'b1});
    send(32'h00000000, 32'h00000001, 4'd5);
    chk("sub_status", status_o, 2'b00);
    chk("sub_b", {b_cls_o, b_exp_o, b_sig_o}, {5'b00010, 8'd1, 24'h000001});
    send(32'h7FC00000, 32'h00000000, 4'd6);
    chk("nan_status", status_o, 2'b10);
    chk("nan_a", {a_cls_o, a_sig_o}, {5'b10000, 24'h400000});
    send(32'hFF800000, 32'h3F800000, 4'd7);
    chk("inf_a", {a_cls_o, status_o, a_sign_o}, {5'b01000, 2'b10, 1'b1});
    drain();
    // backpressure: two held, third refused, then released in order
    out_ready_i = 1'b0;
    send(32'h3F800000, 32'h3F800000, 4'd1);
    send(32'h40000000, 32'h40000000, 4'd2);
    chk("bp_in_ready_low", in_ready_o, 0);
    send(32'h40400000, 32'h40400000, 4'd3);
    chk("bp_hold_tag", {out_valid_o, tag_o}, {1'b1, 4'd1});
    chk("bp_sb_depth", sb.size(), 2);
    npop = 0;
    out_ready_i = 1'b1;
    tick();
    chk("bp_in_ready_high", in_ready_o, 1);
    chk("bp_second_tag", tag_o, 4'd2);
    drain();
    chk("bp_pop_count", npop, 2);
    // flush with both entries held and a valid input present
    out_ready_i = 1'b0;
    send(32'h3F800000, 32'h0, 4'd5);
    send(32'h3F800000, 32'h0, 4'd6);
    flush_i = 1'b1;
    send(32'h3F800000, 32'h0, 4'd7);
    flush_i = 1'b0;
    chk("flush_out_valid", out_valid_o, 0);
    chk("flush_in_ready", in_ready_o, 1);
    drain();
    // flush while ready: the presented input must still be dropped
    out_ready_i = 1'b0;
    send(32'h3F800000, 32'h0, 4'd8);
    flush_i = 1'b1;
    send(32'h40000000, 32'h0, 4'd9);
    flush_i = 1'b0;
    chk("flush1_out_valid", out_valid_o, 0);
    drain();
    // reset with skid full
    out_ready_i = 1'b0;
    send(32'hBF800000, 32'h7F800000, 4'd10);
    send(32'hBF800000, 32'h7F800000, 4'd11);
    chk("pre_rst_full", in_ready_o, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_ctrl", {out_valid_o, in_ready_o}, 2'b01);
    chk("mid_rst_data", obs(), {1'b0, 8'd0, 24'd0, 5'b00001, 1'b0, 8'd0, 24'd0, 5'b00001, 2'b00, 4'd0});
    drain();
    // randomized traffic over special and arbitrary operands
    for (int i = 0; i < 300; i++) begin
      int ka, kb;
      ka = $urandom_range(0, 9);
      kb = $urandom_range(0, 9);
      a_i = (ka < 8) ? vals[ka] : $urandom;
      b_i = (kb < 8) ? vals[kb] : $urandom;
      tag_i = 4'($urandom);
      in_valid_i = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
